// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, MemCtrl and control signals of the memory arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
// Optional macro MEM_ARB_STATS_EN adds the statistics counter outputs.
// ICACHE_LINE_WID sets the fetch line width (defaults to 64 if not defined).
`ifndef ICACHE_LINE_WID
`define ICACHE_LINE_WID 64
`endif

interface mem_arbiter_if;
  logic                        rdy;
  logic                        rollback;

  logic                        if_req;
  logic [31:0]                 if_pc;
  logic                        if_done;
  logic [`ICACHE_LINE_WID-1:0] if_line;

  logic                        lsb_req;
  logic                        lsb_wr;
  logic [31:0]                 lsb_a;
  logic [2:0]                  lsb_l;
  logic [31:0]                 lsb_w;
  logic                        lsb_done;
  logic [31:0]                 lsb_r;

  logic                        mc_if_en;
  logic [31:0]                 mc_if_pc;
  logic                        mc_lsb_en;
  logic                        mc_lsb_wr;
  logic [31:0]                 mc_lsb_a;
  logic [2:0]                  mc_lsb_l;
  logic [31:0]                 mc_lsb_w;

  logic                        mc_if_done;
  logic [`ICACHE_LINE_WID-1:0] mc_if_data;
  logic                        mc_lsb_done;
  logic [31:0]                 mc_lsb_r;

`ifdef MEM_ARB_STATS_EN
  logic [31:0]                 stat_if_grants;
  logic [31:0]                 stat_lsb_grants;
  logic [31:0]                 stat_if_wait;
`endif

  modport slave (
    input  rdy, rollback,
    input  if_req, if_pc,
    output if_done, if_line,
    input  lsb_req, lsb_wr, lsb_a, lsb_l, lsb_w,
    output lsb_done, lsb_r,
    output mc_if_en, mc_if_pc,
    output mc_lsb_en, mc_lsb_wr, mc_lsb_a, mc_lsb_l, mc_lsb_w,
    input  mc_if_done, mc_if_data, mc_lsb_done, mc_lsb_r
`ifdef MEM_ARB_STATS_EN
    , output stat_if_grants, stat_lsb_grants, stat_if_wait
`endif
  );

  modport master (
    output rdy, rollback,
    output if_req, if_pc,
    input  if_done, if_line,
    output lsb_req, lsb_wr, lsb_a, lsb_l, lsb_w,
    input  lsb_done, lsb_r,
    input  mc_if_en, mc_if_pc,
    input  mc_lsb_en, mc_lsb_wr, mc_lsb_a, mc_lsb_l, mc_lsb_w,
    output mc_if_done, mc_if_data, mc_lsb_done, mc_lsb_r
`ifdef MEM_ARB_STATS_EN
    , input stat_if_grants, stat_lsb_grants, stat_if_wait
`endif
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one MemCtrl between the instruction fetch unit and the
// load/store buffer, one transaction outstanding at a time. LSB has priority
// unless the fetch side has been passed over STARVE_LIMIT times in a row.
// Optional macro MEM_ARB_STATS_EN adds grant and fetch-wait counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no transaction; grant decided this cycle unless rollback
// S_BUSY_IF | fetch issued to MemCtrl, waiting for mc_if_done
// S_BUSY_LS | load/store issued to MemCtrl, waiting for mc_lsb_done
// S_DRAIN   | fetch flushed, MemCtrl still finishing it; data discarded
// S_GAP     | one idle cycle for MemCtrl to clear its done flag
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned LW = `ICACHE_LINE_WID;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUSY_IF = 3'd1,
    S_BUSY_LS = 3'd2,
    S_DRAIN   = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            mc_if_en_q, mc_if_en_d;
  logic [31:0]     mc_if_pc_q, mc_if_pc_d;
  logic            mc_lsb_en_q, mc_lsb_en_d;
  logic            mc_lsb_wr_q, mc_lsb_wr_d;
  logic [31:0]     mc_lsb_a_q, mc_lsb_a_d;
  logic [2:0]      mc_lsb_l_q, mc_lsb_l_d;
  logic [31:0]     mc_lsb_w_q, mc_lsb_w_d;
  logic            if_done_q, if_done_d;
  logic [LW-1:0]   if_line_q, if_line_d;
  logic            lsb_done_q, lsb_done_d;
  logic [31:0]     lsb_r_q, lsb_r_d;
  logic            gnt_if, gnt_ls;

`ifdef MEM_ARB_STATS_EN
  logic [31:0]     stat_if_grants_q, stat_if_grants_d;
  logic [31:0]     stat_lsb_grants_q, stat_lsb_grants_d;
  logic [31:0]     stat_if_wait_q, stat_if_wait_d;
`endif

  // Next-state, grant selection and MemCtrl handshake
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mc_if_en_d  = mc_if_en_q;
    mc_if_pc_d  = mc_if_pc_q;
    mc_lsb_en_d = mc_lsb_en_q;
    mc_lsb_wr_d = mc_lsb_wr_q;
    mc_lsb_a_d  = mc_lsb_a_q;
    mc_lsb_l_d  = mc_lsb_l_q;
    mc_lsb_w_d  = mc_lsb_w_q;
    if_done_d   = 1'b0;
    if_line_d   = if_line_q;
    lsb_done_d  = 1'b0;
    lsb_r_d     = lsb_r_q;
    gnt_if      = 1'b0;
    gnt_ls      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.rollback) begin
          if (bus.if_req && (starve_q == STARVE_MAX)) gnt_if = 1'b1;
          else if (bus.lsb_req)                       gnt_ls = 1'b1;
          else if (bus.if_req)                        gnt_if = 1'b1;
        end
      end
      S_BUSY_IF: begin
        if (bus.rollback) begin
          // a done arriving with the flush has already been consumed, skip DRAIN
          mc_if_en_d = 1'b0;
          state_d    = bus.mc_if_done ? S_GAP : S_DRAIN;
        end else if (bus.mc_if_done) begin
          mc_if_en_d = 1'b0;
          if_line_d  = bus.mc_if_data;
          if_done_d  = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_BUSY_LS: begin
        if (bus.mc_lsb_done) begin
          // a store always completes; a flushed load returns nothing
          mc_lsb_en_d = 1'b0;
          lsb_done_d  = mc_lsb_wr_q || !bus.rollback;
          if (!mc_lsb_wr_q && !bus.rollback) lsb_r_d = bus.mc_lsb_r;
          state_d     = S_GAP;
        end else if (bus.rollback && !mc_lsb_wr_q) begin
          mc_lsb_en_d = 1'b0;
          state_d     = S_GAP;
        end
      end
      S_DRAIN: begin
        if (bus.mc_if_done) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (gnt_if) begin
      state_d    = S_BUSY_IF;
      mc_if_en_d = 1'b1;
      mc_if_pc_d = bus.if_pc;
    end
    if (gnt_ls) begin
      state_d     = S_BUSY_LS;
      mc_lsb_en_d = 1'b1;
      mc_lsb_wr_d = bus.lsb_wr;
      mc_lsb_a_d  = bus.lsb_a;
      mc_lsb_l_d  = bus.lsb_l;
      mc_lsb_w_d  = bus.lsb_w;
    end

    if (!bus.if_req || gnt_if)                   starve_d = '0;
    else if (gnt_ls && (starve_q != STARVE_MAX)) starve_d = starve_q + SW'(1);
  end

`ifdef MEM_ARB_STATS_EN
  // Free-running, wrapping statistics
  always_comb begin
    stat_if_grants_d  = stat_if_grants_q + {31'd0, gnt_if};
    stat_lsb_grants_d = stat_lsb_grants_q + {31'd0, gnt_ls};
    stat_if_wait_d    = stat_if_wait_q + {31'd0, (bus.if_req && (state_q != S_BUSY_IF))};
  end
`endif

  // State registers; reset wins over rdy, rdy low freezes everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      mc_if_en_q  <= 1'b0;
      mc_if_pc_q  <= '0;
      mc_lsb_en_q <= 1'b0;
      mc_lsb_wr_q <= 1'b0;
      mc_lsb_a_q  <= '0;
      mc_lsb_l_q  <= '0;
      mc_lsb_w_q  <= '0;
      if_done_q   <= 1'b0;
      if_line_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_r_q     <= '0;
`ifdef MEM_ARB_STATS_EN
      stat_if_grants_q  <= '0;
      stat_lsb_grants_q <= '0;
      stat_if_wait_q    <= '0;
`endif
    end else if (bus.rdy) begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mc_if_en_q  <= mc_if_en_d;
      mc_if_pc_q  <= mc_if_pc_d;
      mc_lsb_en_q <= mc_lsb_en_d;
      mc_lsb_wr_q <= mc_lsb_wr_d;
      mc_lsb_a_q  <= mc_lsb_a_d;
      mc_lsb_l_q  <= mc_lsb_l_d;
      mc_lsb_w_q  <= mc_lsb_w_d;
      if_done_q   <= if_done_d;
      if_line_q   <= if_line_d;
      lsb_done_q  <= lsb_done_d;
      lsb_r_q     <= lsb_r_d;
`ifdef MEM_ARB_STATS_EN
      stat_if_grants_q  <= stat_if_grants_d;
      stat_lsb_grants_q <= stat_lsb_grants_d;
      stat_if_wait_q    <= stat_if_wait_d;
`endif
    end
  end

  assign bus.mc_if_en  = mc_if_en_q;
  assign bus.mc_if_pc  = mc_if_pc_q;
  assign bus.mc_lsb_en = mc_lsb_en_q;
  assign bus.mc_lsb_wr = mc_lsb_wr_q;
  assign bus.mc_lsb_a  = mc_lsb_a_q;
  assign bus.mc_lsb_l  = mc_lsb_l_q;
  assign bus.mc_lsb_w  = mc_lsb_w_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_line   = if_line_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_r     = lsb_r_q;
`ifdef MEM_ARB_STATS_EN
  assign bus.stat_if_grants  = stat_if_grants_q;
  assign bus.stat_lsb_grants = stat_lsb_grants_q;
  assign bus.stat_if_wait    = stat_if_wait_q;
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive LSB grants while IF waits.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 rdy  in  1  global enable; low freezes all state and outputs.
REQ-005 rollback  in  1  pipeline flush.
REQ-006 if_req  in  1  icache line fetch request, held until if_done or rollback.
REQ-007 if_pc  in  32  line base address.
REQ-008 if_done  out  1  one-cycle pulse: if_line valid.
REQ-009 if_line  out  `ICACHE_LINE_WID  fetched line, held until next if_done.
REQ-010 lsb_req  in  1  LSB access request, held until lsb_done or rollback.
REQ-011 lsb_wr / lsb_a / lsb_l / lsb_w  in  1/32/3/32  store flag, address, byte length, store data.
REQ-012 lsb_done  out  1  one-cycle pulse; lsb_r valid for loads.
REQ-013 lsb_r  out  32  load data.
REQ-014 mc_if_en / mc_if_pc  out  1/32  to MemCtrl fetch port.
REQ-015 mc_lsb_en / mc_lsb_wr / mc_lsb_a / mc_lsb_l / mc_lsb_w  out  1/1/32/3/32  to MemCtrl LSB port.
REQ-016 mc_if_done / mc_if_data  in  1/`ICACHE_LINE_WID  MemCtrl fetch completion.
REQ-017 mc_lsb_done / mc_lsb_r  in  1/32  MemCtrl LSB completion.

Function
REQ-018 States: IDLE, BUSY_IF, BUSY_LS, DRAIN, GAP; at most one MemCtrl transaction outstanding.
REQ-019 IDLE, rollback low: grant LSB if lsb_req, else IF if if_req; exception: IF wins if if_req and starve count = STARVE_LIMIT.
REQ-020 Starve count: +1 per LSB grant while if_req high, saturating at STARVE_LIMIT; cleared on IF grant or if_req low.
REQ-021 Grant registers request fields into mc_* and raises exactly one of mc_if_en/mc_lsb_en next cycle; both never high together.
REQ-022 mc_*_en and address/data held stable until matching mc_*_done; enable drops the cycle mc_*_done is sampled.
REQ-023 BUSY_IF + mc_if_done: latch mc_if_data into if_line, pulse if_done next cycle, go GAP.
REQ-024 BUSY_LS + mc_lsb_done: latch mc_lsb_r into lsb_r (stores: unchanged), pulse lsb_done next cycle, go GAP.
REQ-025 GAP lasts exactly one cycle, no grant, then IDLE (MemCtrl done-clear cycle).
REQ-026 Rollback in IDLE: no grant that cycle.
REQ-027 Rollback in BUSY_LS with load: drop mc_lsb_en, no lsb_done, go GAP.
REQ-028 Rollback in BUSY_LS with store: ignored; store completes and lsb_done pulses.
REQ-029 Rollback in BUSY_IF: drop mc_if_en, go DRAIN; DRAIN waits mc_if_done, discards data, no if_done, then GAP.
REQ-030 Rollback coincident with mc_*_done: rollback wins for loads/fetches (no done pulse), done wins for stores.
REQ-031 Stray mc_*_done in IDLE/GAP ignored.

Reset
REQ-032 rst low at clk edge: state IDLE, starve count 0, all mc_*_en, if_done, lsb_done 0; mc_* address/data, if_line, lsb_r 0.
REQ-033 Reset mid-transaction: aborts immediately, no done pulse; rst overrides rdy.

Configuration
REQ-034 MEM_ARB_STATS_EN defined: adds outputs stat_if_grants, stat_lsb_grants, stat_if_wait (32 bit each, wrapping, reset 0); stat_if_wait counts cycles with if_req high and not in BUSY_IF.
REQ-035 MEM_ARB_STATS_EN undefined: stat ports and counters absent; other behaviour identical.

Verification
REQ-036 Lone if_req, pc=0x1000; mc_if_done after 65 cycles -> mc_if_en high cycle 1, if_done pulse one cycle after mc_if_done, if_line = mc_if_data.
REQ-037 if_req and lsb_req (load 0x20, l=4) together -> LSB granted first, GAP one cycle, then IF granted.
REQ-038 lsb_req held continuously, if_req held, STARVE_LIMIT=4 -> IF granted after exactly 4 LSB grants.
REQ-039 Rollback 3 cycles into load -> mc_lsb_en drops next cycle, no lsb_done, next grant after GAP.
REQ-040 Rollback during store 0x30000 -> store finishes, lsb_done pulses; rollback during fetch -> DRAIN until mc_if_done, no if_done.
REQ-041 rdy low 5 cycles mid-fetch -> all outputs frozen; rst low mid-fetch -> all outputs 0 next cycle.
